// File: rtl/sdc_bus_arbiter.sv
// SD bus arbiter: shares one SPI-mode SD card between a write engine and a
// read engine. Round-robin on ties, release on owner done or hold timeout,
// then a fixed idle gap (cs_n high, mosi high) before the next owner.
//
// state | meaning
// IDLE  | bus free, waiting for a request
// GRANT | one engine owns the bus, hold counter running
// GAP   | bus released, gap counter running before requests are sampled again
module sdc_bus_arbiter #(
  parameter int unsigned GAP_CYCLES = 8,
  parameter logic [15:0] TIMEOUT    = 16'd65535
) (
  input  logic clk,
  input  logic reset,
  input  logic req_wr,
  input  logic done_wr,
  input  logic mosi_wr,
  input  logic req_rd,
  input  logic done_rd,
  input  logic mosi_rd,
  output logic gnt_wr,
  output logic gnt_rd,
  output logic mosi,
  output logic cs_n,
  output logic busy,
  output logic timeout
);

  // A zero gap would let two owners touch back to back; clamp it to one clock.
  localparam int unsigned GAP_EFF   = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_EFF - 1);
  localparam logic [15:0] HOLD_LAST = (TIMEOUT == 16'd0) ? 16'd0 : (TIMEOUT - 16'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] hold_cnt;
  logic [15:0] gap_cnt;
  logic        last_rd;
  logic        armed;
  logic        owner_done;

  // Only the current owner's done pulse counts; stray dones are dropped here.
  always_comb begin
    owner_done = (gnt_wr & done_wr) | (gnt_rd & done_rd);
  end

  // Sequencer: grant selection, hold timeout, gap countdown, registered grants.
  // armed holds off the first grant until the second edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gnt_wr   <= 1'b0;
      gnt_rd   <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= 16'd0;
      gap_cnt  <= 16'd0;
      last_rd  <= 1'b1;
      armed    <= 1'b0;
    end else begin
      armed   <= 1'b1;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && (req_wr || req_rd)) begin
            state    <= GRANT;
            hold_cnt <= 16'd0;
            if (req_wr && (!req_rd || last_rd)) begin
              gnt_wr  <= 1'b1;
              last_rd <= 1'b0;
            end else begin
              gnt_rd  <= 1'b1;
              last_rd <= 1'b1;
            end
          end
        end
        GRANT: begin
          hold_cnt <= hold_cnt + 16'd1;
          if (owner_done || (hold_cnt == HOLD_LAST)) begin
            state   <= GAP;
            gnt_wr  <= 1'b0;
            gnt_rd  <= 1'b0;
            gap_cnt <= GAP_LOAD;
            timeout <= ~owner_done;
          end
        end
        GAP: begin
          if (gap_cnt == 16'd0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          gnt_wr <= 1'b0;
          gnt_rd <= 1'b0;
        end
      endcase
    end
  end

  // Card-facing pins follow the registered grants directly so reset drops them at once.
  always_comb begin
    cs_n = ~(gnt_wr | gnt_rd);
    busy = (state != IDLE);
    if (gnt_wr) begin
      mosi = mosi_wr;
    end else if (gnt_rd) begin
      mosi = mosi_rd;
    end else begin
      mosi = 1'b1;
    end
  end

endmodule

// File: tb/tb_sdc_bus_arbiter.sv
// Bench for sdc_bus_arbiter: directed scenarios plus random traffic, all
// compared each cycle against a bus-ownership model kept in the bench.
module tb_sdc_bus_arbiter;

  localparam int GAP = 8;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_wr = 1'b0, done_wr = 1'b0, mosi_wr = 1'b1;
  logic req_rd = 1'b0, done_rd = 1'b0, mosi_rd = 1'b1;
  logic gnt_wr, gnt_rd, mosi, cs_n, busy, timeout;
  logic [5:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // model: owner 0 none / 1 writer / 2 reader
  int m_owner, m_held, m_quiet, m_last;
  bit m_armed, m_to;

  sdc_bus_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(16'(TO))) dut (
    .clk(clk), .reset(reset),
    .req_wr(req_wr), .done_wr(done_wr), .mosi_wr(mosi_wr),
    .req_rd(req_rd), .done_rd(done_rd), .mosi_rd(mosi_rd),
    .gnt_wr(gnt_wr), .gnt_rd(gnt_rd), .mosi(mosi), .cs_n(cs_n),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  assign obs = {gnt_wr, gnt_rd, cs_n, mosi, busy, timeout};

  function automatic logic [5:0] exp_vec();
    logic me;
    me = (m_owner == 1) ? mosi_wr : (m_owner == 2) ? mosi_rd : 1'b1;
    return {m_owner == 1, m_owner == 2, m_owner == 0, me,
            (m_owner != 0) || (m_quiet > 0), m_to};
  endfunction

  task automatic m_reset();
    m_owner = 0; m_held = 0; m_quiet = 0; m_last = 2; m_armed = 0; m_to = 0;
  endtask

  task automatic m_step();
    bit nt;
    nt = 0;
    if (m_owner != 0) begin
      m_held++;
      if ((m_owner == 1 && done_wr) || (m_owner == 2 && done_rd)) begin
        m_owner = 0; m_quiet = GAP;
      end else if (m_held == TO) begin
        m_owner = 0; m_quiet = GAP; nt = 1;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (m_armed && (req_wr || req_rd)) begin
      if (req_wr && req_rd) m_owner = (m_last == 1) ? 2 : 1;
      else m_owner = req_wr ? 1 : 2;
      m_last = m_owner;
      m_held = 0;
    end
    m_armed = 1;
    m_to = nt;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic apply_reset();
    req_wr = 0; req_rd = 0; done_wr = 0; done_rd = 0;
    reset = 1'b0;
    m_reset();
    #2;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Structural invariants on every cycle out of reset.
  always @(negedge clk) begin
    if (reset) begin
      n_cmp++;
      if ((gnt_wr && gnt_rd) || (cs_n !== ~(gnt_wr | gnt_rd))) begin
        n_bad++;
        $display("FAIL invariant t=%0t: gnt_wr=%b gnt_rd=%b cs_n=%b required exclusive grants and cs_n=!(gnt)",
                 $time, gnt_wr, gnt_rd, cs_n);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    m_reset();
    req_wr = 1'b1;
    #3;
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_state: got %b want %b", obs, exp_vec());
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_cmp++;
    if (gnt_wr !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_first_edge_no_grant: gnt_wr=%b want 0", gnt_wr);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset_release t=%0t: got %b want %b", $time, obs, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_single_wr();
    int gcnt;
    apply_reset();
    req_wr = 1'b1;
    gcnt = 0;
    repeat (24) begin
      if (m_owner == 1) req_wr = 1'b0;
      done_wr = (m_owner == 1 && m_held == 5);
      mosi_wr = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL single_wr t=%0t: got %b want %b", $time, obs, exp_vec());
      end
      if (gnt_wr) gcnt++;
      tick();
    end
    done_wr = 1'b0;
    n_cmp++;
    if (gcnt !== 6) begin
      n_bad++;
      $display("FAIL single_wr_len: gnt_wr cycles %0d want 6", gcnt);
    end
  endtask

  task automatic test_round_robin();
    int seq[$];
    apply_reset();
    req_wr = 1'b1; req_rd = 1'b1;
    repeat (70) begin
      done_wr = (m_owner == 1 && m_held == 3);
      done_rd = (m_owner == 2 && m_held == 3);
      mosi_wr = 1'($urandom); mosi_rd = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL round_robin t=%0t: got %b want %b", $time, obs, exp_vec());
      end
      tick();
      if (m_owner != 0 && m_held == 0) seq.push_back(m_owner);
    end
    done_wr = 1'b0; done_rd = 1'b0;
    n_cmp++;
    if (seq.size() < 4 || seq[0] != 1 || seq[1] != 2 || seq[2] != 1 || seq[3] != 2) begin
      n_bad++;
      $display("FAIL round_robin_order: got %p want 1,2,1,2", seq);
    end
  endtask

  task automatic test_timeout();
    int gcnt, tcnt;
    apply_reset();
    req_rd = 1'b1;
    gcnt = 0; tcnt = 0;
    repeat (30) begin
      if (m_owner == 2) req_rd = 1'b0;
      mosi_rd = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL timeout t=%0t: got %b want %b", $time, obs, exp_vec());
      end
      if (gnt_rd) gcnt++;
      if (timeout) tcnt++;
      tick();
    end
    n_cmp++;
    if (gcnt !== TO || tcnt !== 1) begin
      n_bad++;
      $display("FAIL timeout_counts: gnt %0d pulses %0d want %0d and 1", gcnt, tcnt, TO);
    end
  endtask

  task automatic test_done_at_limit();
    int gcnt, tcnt;
    apply_reset();
    req_wr = 1'b1;
    gcnt = 0; tcnt = 0;
    repeat (30) begin
      if (m_owner == 1) req_wr = 1'b0;
      done_wr = (m_owner == 1 && m_held == TO - 1);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL done_at_limit t=%0t: got %b want %b", $time, obs, exp_vec());
      end
      if (gnt_wr) gcnt++;
      if (timeout) tcnt++;
      tick();
    end
    done_wr = 1'b0;
    n_cmp++;
    if (gcnt !== TO || tcnt !== 0) begin
      n_bad++;
      $display("FAIL done_at_limit_counts: gnt %0d pulses %0d want %0d and 0", gcnt, tcnt, TO);
    end
  endtask

  task automatic test_nonowner_done();
    int gcnt;
    apply_reset();
    req_wr = 1'b1;
    gcnt = 0;
    repeat (20) begin
      if (m_owner == 1) req_wr = 1'b0;
      done_rd = (m_owner == 1 && (m_held == 2 || m_held == 4));
      done_wr = (m_owner == 1 && m_held == 6) || (m_quiet == 3);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL nonowner_done t=%0t: got %b want %b", $time, obs, exp_vec());
      end
      if (gnt_wr) gcnt++;
      tick();
    end
    done_wr = 1'b0; done_rd = 1'b0;
    n_cmp++;
    if (gcnt !== 7) begin
      n_bad++;
      $display("FAIL nonowner_done_len: gnt_wr cycles %0d want 7", gcnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    req_wr = 1'b1; mosi_wr = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL mid_grant_pre t=%0t: got %b want %b", $time, obs, exp_vec());
      end
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (gnt_wr !== 1'b0 || cs_n !== 1'b1 || mosi !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_grant_async: gnt_wr=%b cs_n=%b mosi=%b busy=%b want 0 1 1 0",
               gnt_wr, cs_n, mosi, busy);
    end
    m_reset();
    req_wr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_bad++;
      $display("FAIL mid_grant_after: got %b want %b", obs, exp_vec());
    end
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    repeat (800) begin
      req_wr  = 1'($urandom_range(0, 1));
      req_rd  = 1'($urandom_range(0, 1));
      done_wr = ($urandom_range(0, 9) == 0);
      done_rd = ($urandom_range(0, 9) == 0);
      mosi_wr = 1'($urandom);
      mosi_rd = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL random t=%0t: got %b want %b", $time, obs, exp_vec());
      end
      tick();
    end
    req_wr = 0; req_rd = 0; done_wr = 0; done_rd = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_wr();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_nonowner_done();
    test_reset_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdc_bus_arbiter.md
SDC_BUS_ARBITER -- requirements
Module: sdc_bus_arbiter

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 8: number of idle clocks with cs_n high and mosi high between two bus owners.
REQ-002 The block SHALL have parameter TIMEOUT, default 16'd65535: maximum clocks a grant is held without done.
REQ-003 The block SHALL have port clk  input  1  the single system clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_wr  input  1  write engine requests the SD bus; level.
REQ-006 The block SHALL have port done_wr  input  1  write engine releases the bus; one-cycle pulse.
REQ-007 The block SHALL have port mosi_wr  input  1  write engine serial data.
REQ-008 The block SHALL have port req_rd  input  1  read engine requests the SD bus; level.
REQ-009 The block SHALL have port done_rd  input  1  read engine releases the bus; one-cycle pulse.
REQ-010 The block SHALL have port mosi_rd  input  1  read engine serial data.
REQ-011 The block SHALL have port gnt_wr  output  1  write engine owns the bus.
REQ-012 The block SHALL have port gnt_rd  output  1  read engine owns the bus.
REQ-013 The block SHALL have port mosi  output  1  muxed serial data to the card.
REQ-014 The block SHALL have port cs_n  output  1  card chip select, active-low.
REQ-015 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 The block SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, GRANT, GAP.
REQ-018 In IDLE with any req high, the FSM SHALL enter GRANT on the next edge; the grant output is registered, so gnt_x rises one clock after req_x is sampled.
REQ-019 Round-robin: if both requests are high in IDLE, the requester that was NOT the last owner SHALL be granted; after reset the last owner is read, so the writer wins the first tie.
REQ-020 A single request in IDLE SHALL be granted regardless of last owner.
REQ-021 At most one of gnt_wr and gnt_rd SHALL be high in any cycle.
REQ-022 cs_n SHALL be low exactly in the cycles where gnt_wr or gnt_rd is high, and high otherwise.
REQ-023 mosi SHALL equal mosi_wr while gnt_wr is high, mosi_rd while gnt_rd is high, and 1 otherwise; this path is combinational.
REQ-024 In GRANT, a done pulse from the owner SHALL end the grant: gnt, cs_n and mosi release on the next edge, and the FSM enters GAP.
REQ-025 done from the non-owner SHALL be ignored, as SHALL done in IDLE or GAP.
REQ-026 Deassertion of the owner's req during GRANT SHALL be ignored; only done or timeout releases the bus.
REQ-027 A 16-bit hold counter SHALL clear on entry to GRANT and increment on each GRANT cycle.
REQ-028 If TIMEOUT grant cycles elapse without owner done, the grant SHALL drop, the FSM SHALL enter GAP, and timeout SHALL pulse high for the first GAP cycle.
REQ-029 If done arrives in the TIMEOUT-th grant cycle, it SHALL win: normal release and no timeout pulse.
REQ-030 GAP SHALL last exactly GAP_CYCLES clocks, counted by a gap counter, and then return to IDLE; requests are not sampled during GAP.
REQ-031 The last-owner register SHALL update on every grant, including grants that end by timeout.
REQ-032 GAP_CYCLES = 0 SHALL be treated as 1.

Reset
REQ-033 On reset low, the block SHALL asynchronously enter IDLE, with gnt_wr = 0, gnt_rd = 0, cs_n = 1, mosi = 1, busy = 0, timeout = 0, both counters 0, and last owner = read.
REQ-034 Reset asserted during GRANT SHALL drop the grant and cs_n immediately, without waiting for a clock edge.
REQ-035 After reset release, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-036 Bench: req_wr=1 only -> gnt_wr=1 and cs_n=0 one clock later; mosi follows mosi_wr; done_wr pulse -> gnt_wr=0 and cs_n=1 next clock; 8 GAP clocks with busy=1; then IDLE.
REQ-037 Bench: req_wr=req_rd=1 held continuously, with each owner pulsing done after 4 cycles -> grants alternate wr, rd, wr, rd with 8-clock gaps.
REQ-038 Bench: TIMEOUT=16, owner never pulses done -> gnt high exactly 16 clocks, then timeout pulses 1 clock, then GAP.
REQ-039 Bench: TIMEOUT=16, done in the 16th grant cycle -> no timeout pulse.
REQ-040 Bench: done_rd pulse while writer is granted -> no effect; reset pulled low mid-grant -> gnt_wr=0, cs_n=1 and mosi=1 before the next edge.
REQ-041 Bench: assertion checked every cycle -> gnt_wr and gnt_rd never both high; cs_n == !(gnt_wr | gnt_rd).
